pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the counter-based PWM generator: measures an incoming PWM waveform.
- Reports high time and period in clk cycles, with a one-cycle valid strobe per completed period.
- Used to loop back and check the LED/PWM output, or to decode an external PWM command signal.
- pwm_in is asynchronous to clk and is synchronized internally.

Parameters:
- CNT_W, 10, width of the measurement counter and result outputs; MAX = 2^CNT_W-1. Default covers a 256-cycle PWM period without overflow.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  measurement enable; low forces IDLE and holds the outputs.
- pwm_in  input  1  asynchronous PWM input.
- high_cnt  output  CNT_W  high time of the last completed period, in clk cycles.
- period_cnt  output  CNT_W  rise-to-rise period of the last completed period, in clk cycles.
- valid  output  1  one-cycle strobe; high_cnt, period_cnt and overflow are updated in the same cycle.
- overflow  output  1  qualifies valid; the measurement hit MAX (timeout or stuck input).
- level  output  1  synchronized pwm_in level.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, FSM in IDLE, cnt 0, synchronizer flops 0.
  - Reset asserted mid-measurement discards the partial result; no valid is produced.
- Synchronizer and edge detect:
  - Two-flop synchronizer s1→s2, plus a delay flop s3.
  - level = s2; rise = s2 & ~s3; fall = ~s2 & s3.
- Latency: a pwm_in rise sampled at clk edge k makes valid high in the cycle after edge k+2.
  - The delay is identical for both edges, so the counts are exact for pulses of at least 1 cycle.
- Counter cnt (CNT_W bits):
  - Increments every enabled cycle and saturates at MAX.
  - On rise it loads 1.
- FSM states and transitions:
  - IDLE: waits for rise, then → HIGH.
  - HIGH: on fall, hi_tmp <= cnt, then → LOW.
  - LOW: on rise, high_cnt <= hi_tmp, period_cnt <= cnt, overflow <= 0, valid <= 1, then → HIGH. The new period starts in the same cycle (back-to-back measurements, no dead cycle).
- Timeout: when cnt == MAX and no edge occurs that cycle:
  - valid <= 1, overflow <= 1, period_cnt <= MAX, cnt <= 0, FSM → IDLE.
  - high_cnt <= MAX if level is 1, else hi_tmp when in LOW, else 0.
- Simultaneous events: an edge takes priority over timeout in the same cycle.
- Duty cases:
  - 0% duty (constant low) and 100% duty (constant high) report through the timeout path only.
  - A single-cycle high pulse measures high_cnt = 1.
- enable low:
  - FSM → IDLE, cnt → 0, valid forced 0.
  - high_cnt, period_cnt and overflow hold their values.
  - The synchronizer keeps running.
  - After enable returns high, the first valid requires two rises (or a timeout).
- Edge case: high_cnt ≤ period_cnt always holds whenever overflow = 0.

Optional Feature:
- Macro: PWM_CAPTURE_DEGLITCH_EN.
- Defined:
  - A filtered level f replaces s2 for edge detection.
  - f changes only when s2 == s3 and both differ from f.
  - Pulses or gaps of 1 cycle are ignored; latency grows by 1 cycle, equally for both edges.
  - level = f.
- Undefined: no filter; behaviour as above.

Test Plan:
- Counter-driven PWM, period 256, duty 64, CNT_W=10 → from the 2nd rise on, valid every 256 cycles with high_cnt=64, period_cnt=256, overflow=0.
- Duty sweep 1, 128, 255 at period 256 → high_cnt equals the duty value each time, period_cnt=256.
- pwm_in held low after reset, enable=1 → valid with overflow=1, high_cnt=0, period_cnt=1023 after 1023 counted cycles, repeating every 1024 cycles.
- pwm_in held high → overflow=1, high_cnt=1023, period_cnt=1023.
- enable dropped for 10 cycles mid-HIGH at period 256 → no valid; outputs hold the previous 64/256; the next valid is 64/256 after two new rises.
- reset_n pulsed low mid-LOW → outputs 0 immediately; no stale valid; normal results after two rises.
- Additional scenario (PWM_CAPTURE_DEGLITCH_EN only): a 1-cycle glitch inside a 64-cycle high pulse → still high_cnt=64, period_cnt=256.

Source files
------------

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time / period measurement; optional 1-cycle deglitch via PWM_CAPTURE_DEGLITCH_EN
module pwm_capture #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             overflow,
  output logic             level
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, s3;
  logic             lvl, rise, fall;
  logic             timeout, meas_done, hi_load;
  logic [CNT_W-1:0] cnt, hi_tmp, to_high;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef PWM_CAPTURE_DEGLITCH_EN
  // f follows s2 only after two agreeing samples, so both edges gain one cycle
  logic f;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      f <= 1'b0;
    else if (s2 == s3 && s2 != f)
      f <= s2;
  end
  assign lvl  = f;
  assign rise = s2 & s3 & ~f;
  assign fall = ~s2 & ~s3 & f;
`else
  assign lvl  = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
`endif

  assign level = lvl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable)
      state_nxt = IDLE;
    else if (rise)
      state_nxt = HIGH;
    else if (fall && state == HIGH)
      state_nxt = LOW;
    else if (timeout)
      state_nxt = IDLE;
  end

  // An edge in the same cycle as cnt == MAX wins over the timeout
  always_comb begin
    meas_done = enable && (state == LOW) && rise;
    hi_load   = enable && (state == HIGH) && fall;
    timeout   = enable && (cnt == MAX) && !rise && !fall;
    to_high   = '0;
    if (lvl)
      to_high = MAX;
    else if (state == LOW)
      to_high = hi_tmp;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (!enable)
      cnt <= '0;
    else if (rise)
      cnt <= ONE;
    else if (timeout)
      cnt <= '0;
    else if (cnt != MAX)
      cnt <= cnt + ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_tmp     <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
    end else begin
      valid <= meas_done | timeout;
      if (hi_load)
        hi_tmp <= cnt;
      if (meas_done) begin
        high_cnt   <= hi_tmp;
        period_cnt <= cnt;
        overflow   <= 1'b0;
      end else if (timeout) begin
        high_cnt   <= to_high;
        period_cnt <= MAX;
        overflow   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       pwm_in;
  logic [9:0] high_cnt;
  logic [9:0] period_cnt;
  logic       valid;
  logic       overflow;
  logic       level;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rel   = 0;
  int v_hi[$];
  int v_per[$];
  int v_ovf[$];
  int v_cyc[$];

`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam int HI_LAT = 1027;
  int duties[3] = '{2, 128, 254};
`else
  localparam int HI_LAT = 1026;
  int duties[3] = '{1, 128, 255};
`endif

  pwm_capture #(.CNT_W(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .overflow   (overflow),
    .level      (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      v_hi.push_back(int'(high_cnt));
      v_per.push_back(int'(period_cnt));
      v_ovf.push_back(int'(overflow));
      v_cyc.push_back(cyc);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    v_hi.delete();
    v_per.delete();
    v_ovf.delete();
    v_cyc.delete();
  endtask

  task automatic apply_reset(input logic lvl);
    @(negedge clk);
    reset_n = 1'b0;
    pwm_in  = lvl;
    enable  = 1'b1;
    cycles(3);
    reset_n = 1'b1;
    rel     = cyc;
    clear_q();
  endtask

  task automatic drive_period(input int p, input int d);
    pwm_in = 1'b1;
    cycles(d);
    pwm_in = 1'b0;
    cycles(p - d);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    enable  = 1'b1;
    pwm_in  = 1'b1;
    cycles(4);
    n_cmp++; if (high_cnt !== 10'd0)   begin n_bad++; $display("FAIL reset_high_cnt: got %0d expected 0", high_cnt); end
    n_cmp++; if (period_cnt !== 10'd0) begin n_bad++; $display("FAIL reset_period_cnt: got %0d expected 0", period_cnt); end
    n_cmp++; if (valid !== 1'b0)       begin n_bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_cmp++; if (overflow !== 1'b0)    begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_cmp++; if (level !== 1'b0)       begin n_bad++; $display("FAIL reset_level: got %b expected 0", level); end
  endtask

  task automatic test_basic();
    apply_reset(1'b0);
    repeat (4) drive_period(256, 64);
    pwm_in = 1'b1;
    cycles(6);
    n_cmp++; if (v_hi.size() != 4) begin n_bad++; $display("FAIL basic_count: got %0d expected 4", v_hi.size()); end
    foreach (v_hi[i]) begin
      n_cmp++; if (v_hi[i] != 64)  begin n_bad++; $display("FAIL basic_high[%0d]: got %0d expected 64", i, v_hi[i]); end
      n_cmp++; if (v_per[i] != 256) begin n_bad++; $display("FAIL basic_period[%0d]: got %0d expected 256", i, v_per[i]); end
      n_cmp++; if (v_ovf[i] != 0)   begin n_bad++; $display("FAIL basic_overflow[%0d]: got %0d expected 0", i, v_ovf[i]); end
      if (i > 0) begin
        n_cmp++; if (v_cyc[i] - v_cyc[i-1] != 256) begin n_bad++; $display("FAIL basic_gap[%0d]: got %0d expected 256", i, v_cyc[i] - v_cyc[i-1]); end
      end
    end
    n_cmp++; if (level !== 1'b1) begin n_bad++; $display("FAIL basic_level: got %b expected 1", level); end
  endtask

  task automatic test_duty_sweep();
    for (int k = 0; k < 3; k++) begin
      apply_reset(1'b0);
      repeat (2) drive_period(256, duties[k]);
      pwm_in = 1'b1;
      cycles(6);
      n_cmp++; if (v_hi.size() != 2) begin n_bad++; $display("FAIL sweep_count d=%0d: got %0d expected 2", duties[k], v_hi.size()); end
      foreach (v_hi[i]) begin
        n_cmp++; if (v_hi[i] != duties[k]) begin n_bad++; $display("FAIL sweep_high d=%0d [%0d]: got %0d expected %0d", duties[k], i, v_hi[i], duties[k]); end
        n_cmp++; if (v_per[i] != 256)      begin n_bad++; $display("FAIL sweep_period d=%0d [%0d]: got %0d expected 256", duties[k], i, v_per[i]); end
        n_cmp++; if (v_ovf[i] != 0)        begin n_bad++; $display("FAIL sweep_overflow d=%0d [%0d]: got %0d expected 0", duties[k], i, v_ovf[i]); end
      end
    end
  endtask

  task automatic test_stuck_low();
    apply_reset(1'b0);
    cycles(2100);
    n_cmp++; if (v_hi.size() != 2) begin n_bad++; $display("FAIL low_count: got %0d expected 2", v_hi.size()); end
    foreach (v_hi[i]) begin
      n_cmp++; if (v_hi[i] != 0)     begin n_bad++; $display("FAIL low_high[%0d]: got %0d expected 0", i, v_hi[i]); end
      n_cmp++; if (v_per[i] != 1023) begin n_bad++; $display("FAIL low_period[%0d]: got %0d expected 1023", i, v_per[i]); end
      n_cmp++; if (v_ovf[i] != 1)    begin n_bad++; $display("FAIL low_overflow[%0d]: got %0d expected 1", i, v_ovf[i]); end
      n_cmp++; if (v_cyc[i] - rel != 1024 * (i + 1)) begin n_bad++; $display("FAIL low_time[%0d]: got %0d expected %0d", i, v_cyc[i] - rel, 1024 * (i + 1)); end
    end
    n_cmp++; if (level !== 1'b0) begin n_bad++; $display("FAIL low_level: got %b expected 0", level); end
  endtask

  task automatic test_stuck_high();
    apply_reset(1'b1);
    cycles(1100);
    n_cmp++; if (v_hi.size() != 1) begin n_bad++; $display("FAIL high_count: got %0d expected 1", v_hi.size()); end
    if (v_hi.size() > 0) begin
      n_cmp++; if (v_hi[0] != 1023)  begin n_bad++; $display("FAIL high_high: got %0d expected 1023", v_hi[0]); end
      n_cmp++; if (v_per[0] != 1023) begin n_bad++; $display("FAIL high_period: got %0d expected 1023", v_per[0]); end
      n_cmp++; if (v_ovf[0] != 1)    begin n_bad++; $display("FAIL high_overflow: got %0d expected 1", v_ovf[0]); end
      n_cmp++; if (v_cyc[0] - rel != HI_LAT) begin n_bad++; $display("FAIL high_time: got %0d expected %0d", v_cyc[0] - rel, HI_LAT); end
    end
    n_cmp++; if (level !== 1'b1) begin n_bad++; $display("FAIL high_level: got %b expected 1", level); end
  endtask

  task automatic test_enable_drop();
    apply_reset(1'b0);
    repeat (2) drive_period(256, 64);
    pwm_in = 1'b1;
    cycles(6);
    clear_q();
    cycles(14);
    enable = 1'b0;
    cycles(5);
    n_cmp++; if (valid !== 1'b0)        begin n_bad++; $display("FAIL en_valid: got %b expected 0", valid); end
    n_cmp++; if (high_cnt !== 10'd64)   begin n_bad++; $display("FAIL en_hold_high: got %0d expected 64", high_cnt); end
    n_cmp++; if (period_cnt !== 10'd256) begin n_bad++; $display("FAIL en_hold_period: got %0d expected 256", period_cnt); end
    n_cmp++; if (overflow !== 1'b0)     begin n_bad++; $display("FAIL en_hold_overflow: got %b expected 0", overflow); end
    cycles(5);
    enable = 1'b1;
    cycles(34);
    pwm_in = 1'b0;
    cycles(192);
    repeat (2) drive_period(256, 64);
    pwm_in = 1'b1;
    cycles(6);
    n_cmp++; if (v_hi.size() != 2) begin n_bad++; $display("FAIL en_count: got %0d expected 2", v_hi.size()); end
    foreach (v_hi[i]) begin
      n_cmp++; if (v_hi[i] != 64)   begin n_bad++; $display("FAIL en_high[%0d]: got %0d expected 64", i, v_hi[i]); end
      n_cmp++; if (v_per[i] != 256) begin n_bad++; $display("FAIL en_period[%0d]: got %0d expected 256", i, v_per[i]); end
      n_cmp++; if (v_ovf[i] != 0)   begin n_bad++; $display("FAIL en_overflow[%0d]: got %0d expected 0", i, v_ovf[i]); end
    end
  endtask

  task automatic test_reset_mid_low();
    apply_reset(1'b0);
    repeat (2) drive_period(256, 64);
    pwm_in = 1'b1;
    cycles(64);
    pwm_in = 1'b0;
    cycles(80);
    clear_q();
    reset_n = 1'b0;
    #1;
    n_cmp++; if (high_cnt !== 10'd0)   begin n_bad++; $display("FAIL rst_high: got %0d expected 0", high_cnt); end
    n_cmp++; if (period_cnt !== 10'd0) begin n_bad++; $display("FAIL rst_period: got %0d expected 0", period_cnt); end
    n_cmp++; if (valid !== 1'b0)       begin n_bad++; $display("FAIL rst_valid: got %b expected 0", valid); end
    n_cmp++; if (overflow !== 1'b0)    begin n_bad++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    cycles(3);
    reset_n = 1'b1;
    cycles(109);
    repeat (2) drive_period(256, 64);
    pwm_in = 1'b1;
    cycles(6);
    n_cmp++; if (v_hi.size() != 2) begin n_bad++; $display("FAIL rst_count: got %0d expected 2", v_hi.size()); end
    foreach (v_hi[i]) begin
      n_cmp++; if (v_hi[i] != 64)   begin n_bad++; $display("FAIL rst_after_high[%0d]: got %0d expected 64", i, v_hi[i]); end
      n_cmp++; if (v_per[i] != 256) begin n_bad++; $display("FAIL rst_after_period[%0d]: got %0d expected 256", i, v_per[i]); end
      n_cmp++; if (v_ovf[i] != 0)   begin n_bad++; $display("FAIL rst_after_overflow[%0d]: got %0d expected 0", i, v_ovf[i]); end
    end
  endtask

`ifdef PWM_CAPTURE_DEGLITCH_EN
  task automatic test_deglitch();
    apply_reset(1'b0);
    repeat (3) begin
      pwm_in = 1'b1; cycles(30);
      pwm_in = 1'b0; cycles(1);
      pwm_in = 1'b1; cycles(33);
      pwm_in = 1'b0; cycles(100);
      pwm_in = 1'b1; cycles(1);
      pwm_in = 1'b0; cycles(91);
    end
    pwm_in = 1'b1;
    cycles(6);
    n_cmp++; if (v_hi.size() != 3) begin n_bad++; $display("FAIL dg_count: got %0d expected 3", v_hi.size()); end
    foreach (v_hi[i]) begin
      n_cmp++; if (v_hi[i] != 64)   begin n_bad++; $display("FAIL dg_high[%0d]: got %0d expected 64", i, v_hi[i]); end
      n_cmp++; if (v_per[i] != 256) begin n_bad++; $display("FAIL dg_period[%0d]: got %0d expected 256", i, v_per[i]); end
      n_cmp++; if (v_ovf[i] != 0)   begin n_bad++; $display("FAIL dg_overflow[%0d]: got %0d expected 0", i, v_ovf[i]); end
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    pwm_in  = 1'b0;
    test_reset();
    test_basic();
    test_duty_sweep();
    test_stuck_low();
    test_stuck_high();
    test_enable_drop();
    test_reset_mid_low();
`ifdef PWM_CAPTURE_DEGLITCH_EN
    test_deglitch();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
